ysyx_25020032_axi_arbiter: RTL and testbench

- Two-master to one-master AXI4 arbiter directly upstream of the ysyx_25020032_Xbar slave port (s_*).
- Master 0 is the IFU, read-only. Master 1 is the LSU, read and write.
- Serialises all traffic: exactly one transaction (read or write) is outstanding downstream at any time. The Xbar decodes on both s_araddr and s_awaddr, so this is required.
- Holds the granted address stable on the downstream port until the response completes.

---
 rtl/ysyx_25020032_axi_arbiter_pkg.sv | 18 +
 rtl/ysyx_25020032_axi_arbiter_grant.sv | 55 +++++
 rtl/ysyx_25020032_axi_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_ysyx_25020032_axi_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25020032_axi_arbiter_pkg.sv
// Shared definitions for the IFU/LSU -> Xbar AXI arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin read arbitration).
package ysyx_25020032_axi_arbiter_pkg;

  // Arbiter FSM encoding; also the grant code produced by the winner select.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IFU = 2'd1,
    RD_LSU = 2'd2,
    WR_LSU = 2'd3
  } arb_state_e;

  // AXI response codes and burst type.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/ysyx_25020032_axi_arbiter_grant.sv
// Winner select for the arbiter. Writes always win; reads use fixed
// priority (LSU over IFU) by default, or round-robin when ARB_ROUND_ROBIN_EN
// is defined, in which case a last_rd_master flop remembers who was served.
module ysyx_25020032_axi_arbiter_grant
  import ysyx_25020032_axi_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       lsu_awvalid_i,
  input  logic       lsu_arvalid_i,
  input  logic       ifu_arvalid_i,
  input  logic       rd_done_i,
  input  logic       rd_done_lsu_i,
  output arb_state_e grant_o
);

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = IFU was served last, 1 = LSU was served last.
  logic last_rd_lsu_q, last_rd_lsu_d;

  // Remember which master completed the most recent read.
  always_comb begin
    last_rd_lsu_d = last_rd_lsu_q;
    if (rd_done_i) last_rd_lsu_d = rd_done_lsu_i;
  end

  // Round-robin history flop, reset to IFU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_rd_lsu_q <= 1'b0;
    else      last_rd_lsu_q <= last_rd_lsu_d;
  end

  // Write first; on a read tie the master not served last wins.
  always_comb begin
    grant_o = IDLE;
    if (lsu_awvalid_i)                      grant_o = WR_LSU;
    else if (lsu_arvalid_i && ifu_arvalid_i) grant_o = last_rd_lsu_q ? RD_IFU : RD_LSU;
    else if (lsu_arvalid_i)                 grant_o = RD_LSU;
    else if (ifu_arvalid_i)                 grant_o = RD_IFU;
  end
`else
  // No history is kept in fixed-priority mode.
  logic unused_grant_inputs;
  assign unused_grant_inputs = ^{clk, rst, rd_done_i, rd_done_lsu_i};

  // Fixed priority: LSU write > LSU read > IFU read.
  always_comb begin
    grant_o = IDLE;
    if (lsu_awvalid_i)      grant_o = WR_LSU;
    else if (lsu_arvalid_i) grant_o = RD_LSU;
    else if (ifu_arvalid_i) grant_o = RD_IFU;
  end
`endif

endmodule

// File: rtl/ysyx_25020032_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4 arbiter in
// front of the Xbar. Exactly one transaction is outstanding downstream; the
// granted address is registered and held until its response completes, and
// the inactive address channel is driven to 0.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin read arbitration).
//
// Handshakes: a beat transfers on a rising clk edge where valid & ready are
// both 1. Upstream readies are the downstream readies routed back in the
// same cycle, masked by the *_done flags so each AR/AW/W-last transfers once.
module ysyx_25020032_axi_arbiter
  import ysyx_25020032_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  // IFU read
  input  logic [ID_W-1:0]     ifu_arid,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic [7:0]          ifu_arlen,
  input  logic [2:0]          ifu_arsize,
  input  logic [1:0]          ifu_arburst,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [ID_W-1:0]     ifu_rid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rlast,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  // LSU read
  input  logic [ID_W-1:0]     lsu_arid,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [7:0]          lsu_arlen,
  input  logic [2:0]          lsu_arsize,
  input  logic [1:0]          lsu_arburst,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [ID_W-1:0]     lsu_rid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rlast,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  // LSU write
  input  logic [ID_W-1:0]     lsu_awid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [7:0]          lsu_awlen,
  input  logic [2:0]          lsu_awsize,
  input  logic [1:0]          lsu_awburst,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wlast,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  output logic [ID_W-1:0]     lsu_bid,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  // Downstream (Xbar slave port)
  output logic [ID_W-1:0]     s_arid,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [ID_W-1:0]     s_rid,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rlast,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ID_W-1:0]     s_awid,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wlast,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [ID_W-1:0]     s_bid,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  // Debug view of the FSM
  output arb_state_e          dbg_state_o
);

  arb_state_e        state_q, state_d, grant;
  logic [ID_W-1:0]   req_id_q, req_id_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [7:0]        req_len_q, req_len_d;
  logic [2:0]        req_size_q, req_size_d;
  logic [1:0]        req_burst_q, req_burst_d;
  logic              ar_done_q, ar_done_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic ar_hs, aw_hs, wlast_hs, rlast_hs, b_hs, rd_done;

  assign ar_hs    = s_arvalid & s_arready;
  assign aw_hs    = s_awvalid & s_awready;
  assign wlast_hs = s_wvalid & s_wready & s_wlast;
  assign rlast_hs = s_rvalid & s_rready & s_rlast;
  assign b_hs     = s_bvalid & s_bready;
  // s_rready is only ever high in a read state.
  assign rd_done  = rlast_hs;

  assign dbg_state_o = state_q;

  ysyx_25020032_axi_arbiter_grant u_grant (
    .clk           (clk),
    .rst           (rst),
    .lsu_awvalid_i (lsu_awvalid),
    .lsu_arvalid_i (lsu_arvalid),
    .ifu_arvalid_i (ifu_arvalid),
    .rd_done_i     (rd_done),
    .rd_done_lsu_i (state_q == RD_LSU),
    .grant_o       (grant)
  );

  // Next state: latch the winner's request in IDLE, track per-channel
  // completion, and return to IDLE on the final response.
  always_comb begin
    state_d     = state_q;
    req_id_d    = req_id_q;
    req_addr_d  = req_addr_q;
    req_len_d   = req_len_q;
    req_size_d  = req_size_q;
    req_burst_d = req_burst_q;
    ar_done_d   = ar_done_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    case (state_q)
      IDLE: begin
        state_d = grant;
        case (grant)
          WR_LSU: begin
            req_id_d = lsu_awid; req_addr_d = lsu_awaddr; req_len_d = lsu_awlen;
            req_size_d = lsu_awsize; req_burst_d = lsu_awburst;
          end
          RD_LSU: begin
            req_id_d = lsu_arid; req_addr_d = lsu_araddr; req_len_d = lsu_arlen;
            req_size_d = lsu_arsize; req_burst_d = lsu_arburst;
          end
          RD_IFU: begin
            req_id_d = ifu_arid; req_addr_d = ifu_araddr; req_len_d = ifu_arlen;
            req_size_d = ifu_arsize; req_burst_d = ifu_arburst;
          end
          default: ;
        endcase
      end
      RD_IFU, RD_LSU: begin
        if (ar_hs) ar_done_d = 1'b1;
        if (rlast_hs) state_d = IDLE;
      end
      WR_LSU: begin
        if (aw_hs)    aw_done_d = 1'b1;
        if (wlast_hs) w_done_d  = 1'b1;
        if (b_hs)     state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Leaving a transaction clears everything so IDLE is a clean slate.
    if (state_q != IDLE && state_d == IDLE) begin
      req_id_d = '0; req_addr_d = '0; req_len_d = '0; req_size_d = '0; req_burst_d = '0;
      ar_done_d = 1'b0; aw_done_d = 1'b0; w_done_d = 1'b0;
    end
  end

  // State and request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_id_q    <= '0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      req_size_q  <= '0;
      req_burst_q <= '0;
      ar_done_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_id_q    <= req_id_d;
      req_addr_q  <= req_addr_d;
      req_len_q   <= req_len_d;
      req_size_q  <= req_size_d;
      req_burst_q <= req_burst_d;
      ar_done_q   <= ar_done_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

  // Channel routing: everything idles at 0, the active state connects only
  // the granted master's channels.
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rid = '0; ifu_rdata = '0; ifu_rresp = '0; ifu_rlast = 1'b0; ifu_rvalid = 1'b0;
    lsu_arready = 1'b0;
    lsu_rid = '0; lsu_rdata = '0; lsu_rresp = '0; lsu_rlast = 1'b0; lsu_rvalid = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bid = '0; lsu_bresp = '0; lsu_bvalid = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = 1'b0;
    s_rready = 1'b0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b0;
    case (state_q)
      RD_IFU, RD_LSU: begin
        s_arid = req_id_q; s_araddr = req_addr_q; s_arlen = req_len_q;
        s_arsize = req_size_q; s_arburst = req_burst_q;
        s_arvalid = ~ar_done_q;
        if (state_q == RD_IFU) begin
          ifu_arready = s_arready & ~ar_done_q;
          ifu_rid = s_rid; ifu_rdata = s_rdata; ifu_rresp = s_rresp; ifu_rlast = s_rlast;
          ifu_rvalid = s_rvalid;
          s_rready = ifu_rready;
        end else begin
          lsu_arready = s_arready & ~ar_done_q;
          lsu_rid = s_rid; lsu_rdata = s_rdata; lsu_rresp = s_rresp; lsu_rlast = s_rlast;
          lsu_rvalid = s_rvalid;
          s_rready = lsu_rready;
        end
      end
      WR_LSU: begin
        s_awid = req_id_q; s_awaddr = req_addr_q; s_awlen = req_len_q;
        s_awsize = req_size_q; s_awburst = req_burst_q;
        s_awvalid   = ~aw_done_q;
        lsu_awready = s_awready & ~aw_done_q;
        s_wdata = lsu_wdata; s_wstrb = lsu_wstrb; s_wlast = lsu_wlast;
        s_wvalid   = lsu_wvalid & ~w_done_q;
        lsu_wready = s_wready & ~w_done_q;
        lsu_bid = s_bid; lsu_bresp = s_bresp; lsu_bvalid = s_bvalid;
        s_bready = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25020032_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter; the bench plays the
// downstream slave and both upstream masters.
module tb_ysyx_25020032_axi_arbiter;
  import ysyx_25020032_axi_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [3:0]  ifu_arid, lsu_arid, lsu_awid, s_arid, s_awid, s_rid, s_bid;
  logic [3:0]  ifu_rid, lsu_rid, lsu_bid;
  logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, s_araddr, s_awaddr;
  logic [7:0]  ifu_arlen, lsu_arlen, lsu_awlen, s_arlen, s_awlen;
  logic [2:0]  ifu_arsize, lsu_arsize, lsu_awsize, s_arsize, s_awsize;
  logic [1:0]  ifu_arburst, lsu_arburst, lsu_awburst, s_arburst, s_awburst;
  logic        ifu_arvalid, ifu_arready, lsu_arvalid, lsu_arready, lsu_awvalid, lsu_awready;
  logic [31:0] ifu_rdata, lsu_rdata, lsu_wdata, s_wdata, s_rdata;
  logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp, s_rresp, s_bresp;
  logic        ifu_rlast, ifu_rvalid, ifu_rready, lsu_rlast, lsu_rvalid, lsu_rready;
  logic [3:0]  lsu_wstrb, s_wstrb;
  logic        lsu_wlast, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  arb_state_e  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int aw_hs_cnt = 0;
  int w_hs_cnt  = 0;
  int waited;

  ysyx_25020032_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_arid(ifu_arid), .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
    .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst), .ifu_arvalid(ifu_arvalid),
    .ifu_arready(ifu_arready), .ifu_rid(ifu_rid), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rvalid(ifu_rvalid),
    .ifu_rready(ifu_rready),
    .lsu_arid(lsu_arid), .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen),
    .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst), .lsu_arvalid(lsu_arvalid),
    .lsu_arready(lsu_arready), .lsu_rid(lsu_rid), .lsu_rdata(lsu_rdata),
    .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rvalid(lsu_rvalid),
    .lsu_rready(lsu_rready),
    .lsu_awid(lsu_awid), .lsu_awaddr(lsu_awaddr), .lsu_awlen(lsu_awlen),
    .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst), .lsu_awvalid(lsu_awvalid),
    .lsu_awready(lsu_awready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wlast(lsu_wlast), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bid(lsu_bid), .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid),
    .lsu_bready(lsu_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready),
    .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Downstream AW/W handshake counters.
  always @(posedge clk) begin
    if (s_awvalid && s_awready) aw_hs_cnt <= aw_hs_cnt + 1;
    if (s_wvalid && s_wready)   w_hs_cnt  <= w_hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=0x%0h exp=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    ifu_arid = '0; ifu_araddr = '0; ifu_arlen = '0; ifu_arsize = '0; ifu_arburst = '0;
    ifu_arvalid = 0; ifu_rready = 0;
    lsu_arid = '0; lsu_araddr = '0; lsu_arlen = '0; lsu_arsize = '0; lsu_arburst = '0;
    lsu_arvalid = 0; lsu_rready = 0;
    lsu_awid = '0; lsu_awaddr = '0; lsu_awlen = '0; lsu_awsize = '0; lsu_awburst = '0;
    lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wlast = 0; lsu_wvalid = 0;
    lsu_bready = 0;
    s_arready = 0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 0; s_rvalid = 0;
    s_awready = 0; s_wready = 0; s_bid = '0; s_bresp = '0; s_bvalid = 0;
  endtask

  task automatic set_ifu_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    ifu_araddr = addr; ifu_arid = id; ifu_arlen = len; ifu_arsize = 3'd2;
    ifu_arburst = BURST_INCR; ifu_arvalid = 1;
  endtask

  task automatic set_lsu_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    lsu_araddr = addr; lsu_arid = id; lsu_arlen = len; lsu_arsize = 3'd2;
    lsu_arburst = BURST_INCR; lsu_arvalid = 1;
  endtask

  task automatic set_lsu_aw(input logic [31:0] addr, input logic [3:0] id,
                            input logic [31:0] wdata, input logic [3:0] strb);
    lsu_awaddr = addr; lsu_awid = id; lsu_awlen = 8'd0; lsu_awsize = 3'd2;
    lsu_awburst = BURST_INCR; lsu_awvalid = 1;
    lsu_wdata = wdata; lsu_wstrb = strb; lsu_wlast = 1; lsu_wvalid = 1;
  endtask

  // Slave side of one read: wait for grant, AR after ar_delay stall cycles,
  // then `beats` R beats with data data0+i.
  task automatic slave_read(input logic is_lsu, input logic [31:0] exp_addr,
                            input logic [3:0] exp_id, input int ar_delay, input int beats,
                            input logic [31:0] data0, output int n_wait);
    arb_state_e exp_st;
    exp_st = is_lsu ? RD_LSU : RD_IFU;
    n_wait = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      n_wait++;
      if (dbg_state == exp_st) break;
    end
    chk("rd_grant_state", dbg_state, exp_st);
    if (dbg_state != exp_st) return;
    chk("s_araddr", s_araddr, exp_addr);
    chk("s_arid", s_arid, exp_id);
    chk("s_arlen", s_arlen, beats - 1);
    chk("s_arvalid", s_arvalid, 1);
    chk("s_awaddr_in_rd", s_awaddr, 0);
    for (int i = 0; i < ar_delay; i++) begin
      @(negedge clk); #1;
      chk("s_arvalid_hold", s_arvalid, 1);
      chk("arready_stall", is_lsu ? lsu_arready : ifu_arready, 0);
    end
    s_arready = 1; #1;
    chk("arready_hs", is_lsu ? lsu_arready : ifu_arready, 1);
    chk("other_arready", is_lsu ? ifu_arready : lsu_arready, 0);
    @(negedge clk);
    s_arready = 0;
    if (is_lsu) lsu_arvalid = 0; else ifu_arvalid = 0;
    #1;
    chk("s_arvalid_done", s_arvalid, 0);
    for (int i = 0; i < beats; i++) begin
      s_rvalid = 1; s_rid = exp_id; s_rdata = data0 + i; s_rresp = RESP_OKAY;
      s_rlast = (i == beats - 1);
      if (is_lsu) lsu_rready = 1; else ifu_rready = 1;
      #1;
      chk("rvalid", is_lsu ? lsu_rvalid : ifu_rvalid, 1);
      chk("rdata", is_lsu ? lsu_rdata : ifu_rdata, data0 + i);
      chk("rid", is_lsu ? lsu_rid : ifu_rid, exp_id);
      chk("rlast", is_lsu ? lsu_rlast : ifu_rlast, (i == beats - 1));
      chk("other_rvalid", is_lsu ? ifu_rvalid : lsu_rvalid, 0);
      chk("other_arready_beat", is_lsu ? ifu_arready : lsu_arready, 0);
      chk("s_rready", s_rready, 1);
      chk("s_araddr_held", s_araddr, exp_addr);
      chk("s_awaddr_zero", s_awaddr, 0);
      chk("s_awvalid_zero", s_awvalid, 0);
      chk("lsu_awready_zero", lsu_awready, 0);
      @(negedge clk);
    end
    s_rvalid = 0; s_rlast = 0; ifu_rready = 0; lsu_rready = 0;
    #1;
    chk("rd_back_idle", dbg_state, IDLE);
    chk("s_araddr_idle", s_araddr, 0);
  endtask

  // Slave side of one single-beat write; w_first accepts W a cycle before AW.
  task automatic slave_write(input logic [31:0] exp_addr, input logic [3:0] exp_id,
                             input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                             input logic w_first, input logic [1:0] bresp, output int n_wait);
    int aw0, w0;
    n_wait = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      n_wait++;
      if (dbg_state == WR_LSU) break;
    end
    chk("wr_grant_state", dbg_state, WR_LSU);
    if (dbg_state != WR_LSU) return;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    chk("s_awaddr", s_awaddr, exp_addr);
    chk("s_awid", s_awid, exp_id);
    chk("s_araddr_in_wr", s_araddr, 0);
    chk("s_awvalid", s_awvalid, 1);
    chk("s_wvalid", s_wvalid, 1);
    chk("s_wdata", s_wdata, exp_wdata);
    chk("s_wstrb", s_wstrb, exp_strb);
    if (w_first) begin
      s_wready = 1; #1;
      chk("lsu_wready_first", lsu_wready, 1);
      chk("lsu_awready_stall", lsu_awready, 0);
      @(negedge clk); #1;
      chk("s_wvalid_masked", s_wvalid, 0);
      chk("lsu_wready_masked", lsu_wready, 0);
      chk("s_awvalid_pending", s_awvalid, 1);
      lsu_wvalid = 0; s_wready = 0; s_awready = 1; #1;
      chk("lsu_awready_late", lsu_awready, 1);
      @(negedge clk);
      s_awready = 0; lsu_awvalid = 0; #1;
    end else begin
      s_awready = 1; s_wready = 1; #1;
      chk("lsu_awready", lsu_awready, 1);
      chk("lsu_wready", lsu_wready, 1);
      @(negedge clk);
      s_awready = 0; s_wready = 0; lsu_awvalid = 0; lsu_wvalid = 0; #1;
    end
    chk("s_awvalid_done", s_awvalid, 0);
    s_bvalid = 1; s_bid = exp_id; s_bresp = bresp; lsu_bready = 1; #1;
    chk("lsu_bvalid", lsu_bvalid, 1);
    chk("lsu_bresp", lsu_bresp, bresp);
    chk("lsu_bid", lsu_bid, exp_id);
    chk("s_bready", s_bready, 1);
    chk("s_awaddr_held", s_awaddr, exp_addr);
    @(negedge clk);
    s_bvalid = 0; lsu_bready = 0; #1;
    chk("wr_back_idle", dbg_state, IDLE);
    chk("aw_hs_once", aw_hs_cnt - aw0, 1);
    chk("w_hs_once", w_hs_cnt - w0, 1);
    chk("s_awaddr_idle", s_awaddr, 0);
  endtask

  initial begin
    clear_inputs();
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", dbg_state, IDLE);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_awvalid", s_awvalid, 0);
    chk("rst_s_wvalid", s_wvalid, 0);
    chk("rst_readies", {ifu_arready, lsu_arready, lsu_awready, lsu_wready}, 0);
    chk("rst_addrs", {s_araddr, s_awaddr}, 0);
    @(negedge clk);
    rst = 1;
    // Stray responses in IDLE are not accepted.
    s_rvalid = 1; s_rlast = 1; s_bvalid = 1; ifu_rready = 1; lsu_rready = 1; lsu_bready = 1;
    #1;
    chk("idle_s_rready", s_rready, 0);
    chk("idle_s_bready", s_bready, 0);
    chk("idle_up_valids", {ifu_rvalid, lsu_rvalid, lsu_bvalid}, 0);
    clear_inputs();

    // IFU single read with AR stalled for 2 cycles.
    @(negedge clk);
    set_ifu_ar(32'h3000_0000, 4'h1, 8'd0);
    slave_read(1'b0, 32'h3000_0000, 4'h1, 2, 1, 32'hDEAD_BEEF, waited);
    chk("t1_grant_latency", waited, 1);

    // Simultaneous reads, IFU served last: LSU first in both modes.
    @(negedge clk);
    set_ifu_ar(32'h3000_0004, 4'h2, 8'd0);
    set_lsu_ar(32'h8000_0010, 4'h3, 8'd0);
    slave_read(1'b1, 32'h8000_0010, 4'h3, 0, 1, 32'h1111_1111, waited);
    slave_read(1'b0, 32'h3000_0004, 4'h2, 0, 1, 32'h2222_2222, waited);
    chk("t2_ifu_wait", waited, 1);

    // LSU served last, then both request again.
    @(negedge clk);
    set_lsu_ar(32'h8000_0020, 4'h4, 8'd0);
    slave_read(1'b1, 32'h8000_0020, 4'h4, 1, 1, 32'h3333_3333, waited);
    @(negedge clk);
    set_ifu_ar(32'h3000_0008, 4'h5, 8'd0);
    set_lsu_ar(32'h8000_0030, 4'h6, 8'd0);
`ifdef ARB_ROUND_ROBIN_EN
    slave_read(1'b0, 32'h3000_0008, 4'h5, 0, 1, 32'h4444_4444, waited);
    slave_read(1'b1, 32'h8000_0030, 4'h6, 0, 1, 32'h5555_5555, waited);
`else
    slave_read(1'b1, 32'h8000_0030, 4'h6, 0, 1, 32'h5555_5555, waited);
    slave_read(1'b0, 32'h3000_0008, 4'h5, 0, 1, 32'h4444_4444, waited);
`endif

    // Write arrives during an IFU 4-beat burst and waits for rlast.
    @(negedge clk);
    set_ifu_ar(32'h3000_0100, 4'h7, 8'd3);
    @(negedge clk);
    set_lsu_aw(32'ha000_0048, 4'h8, 32'h0000_0001, 4'hF);
    slave_read(1'b0, 32'h3000_0100, 4'h7, 0, 4, 32'hC0DE_0000, waited);
    slave_write(32'ha000_0048, 4'h8, 32'h0000_0001, 4'hF, 1'b0, RESP_DECERR, waited);
    chk("t4_wr_wait", waited, 1);

    // W accepted before AW.
    @(negedge clk);
    set_lsu_aw(32'ha000_0050, 4'h9, 32'h0000_55AA, 4'h3);
    slave_write(32'ha000_0050, 4'h9, 32'h0000_55AA, 4'h3, 1'b1, RESP_OKAY, waited);

    // Asynchronous reset in the middle of an LSU burst.
    @(negedge clk);
    set_lsu_ar(32'h8000_0040, 4'hA, 8'd3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (dbg_state == RD_LSU) break;
    end
    chk("t6_grant", dbg_state, RD_LSU);
    s_arready = 1;
    @(negedge clk);
    s_arready = 0; lsu_arvalid = 0;
    s_rvalid = 1; s_rlast = 0; s_rdata = 32'h6666_6666; s_rid = 4'hA; lsu_rready = 1;
    #1;
    chk("t6_beat0", lsu_rvalid, 1);
    #1;
    rst = 0;
    #1;
    chk("t6_rst_state", dbg_state, IDLE);
    chk("t6_rst_valids", {s_arvalid, s_awvalid, s_wvalid, lsu_rvalid, ifu_rvalid, lsu_bvalid}, 0);
    chk("t6_rst_readies", {s_rready, s_bready, ifu_arready, lsu_arready, lsu_awready, lsu_wready}, 0);
    chk("t6_rst_araddr", s_araddr, 0);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rst = 1;
    set_ifu_ar(32'h3000_0200, 4'hB, 8'd0);
    slave_read(1'b0, 32'h3000_0200, 4'hB, 0, 1, 32'h7777_7777, waited);
    chk("t6_post_rst_latency", waited, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
